// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester and UART transmit handshake bundle for uart_tx_sched
interface uart_tx_sched_if;
   logic        ack_req;
   logic [7:0]  ack_byte;
   logic        tel_req;
   logic [23:0] tel_data;
   logic        tx_done;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        ack_gnt;
   logic        tel_gnt;
   logic        busy;
   logic        frame_done;
   logic        frame_src;
   modport slave (
      input  ack_req, ack_byte, tel_req, tel_data, tx_done,
      output trmt, tx_data, ack_gnt, tel_gnt, busy, frame_done, frame_src
   );
   modport master (
      output ack_req, ack_byte, tel_req, tel_data, tx_done,
      input  trmt, tx_data, ack_gnt, tel_gnt, busy, frame_done, frame_src
   );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between a 1-byte ack path and a 3-byte telemetry stream; TEL_CHKSUM_EN adds a telemetry checksum byte
module uart_tx_sched #(
   parameter bit ACK_PRIORITY = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   uart_tx_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;
   state_t      state, state_n;
   logic [23:0] shift, shift_n;
   logic [2:0]  cnt, cnt_n;
   logic        last_tel, last_tel_n;
   logic        trmt_n, ack_gnt_n, tel_gnt_n, busy_n, frame_done_n, frame_src_n;
   logic [7:0]  tx_data_n;
   logic        pick_ack;
   logic [7:0]  chk;
`ifdef TEL_CHKSUM_EN
   localparam logic [2:0] TEL_LEN = 3'd4;
   assign chk = bus.tel_data[23:16] + bus.tel_data[15:8] + bus.tel_data[7:0];
`else
   localparam logic [2:0] TEL_LEN = 3'd3;
   assign chk = 8'h00;
`endif
   assign pick_ack = bus.ack_req & (~bus.tel_req | ACK_PRIORITY | last_tel);
   // next-state and next-output decode; the first byte leaves straight from the grant decision
   always_comb begin
      state_n      = state;
      shift_n      = shift;
      cnt_n        = cnt;
      last_tel_n   = last_tel;
      trmt_n       = 1'b0;
      tx_data_n    = bus.tx_data;
      ack_gnt_n    = 1'b0;
      tel_gnt_n    = 1'b0;
      busy_n       = bus.busy;
      frame_done_n = 1'b0;
      frame_src_n  = bus.frame_src;
      case (state)
         IDLE: if (bus.ack_req | bus.tel_req) begin
            state_n     = SEND;
            trmt_n      = 1'b1;
            busy_n      = 1'b1;
            ack_gnt_n   = pick_ack;
            tel_gnt_n   = ~pick_ack;
            frame_src_n = ~pick_ack;
            last_tel_n  = ~pick_ack;
            tx_data_n   = pick_ack ? bus.ack_byte : bus.tel_data[23:16];
            shift_n     = pick_ack ? 24'h0 : {bus.tel_data[15:0], chk};
            cnt_n       = pick_ack ? 3'd0 : TEL_LEN - 3'd1;
         end
         SEND:  state_n = GUARD;
         GUARD: state_n = WAIT;
         WAIT: if (bus.tx_done) begin
            if (cnt != 3'd0) begin
               state_n   = SEND;
               trmt_n    = 1'b1;
               tx_data_n = shift[23:16];
               shift_n   = {shift[15:0], 8'h00};
               cnt_n     = cnt - 3'd1;
            end else begin
               state_n      = IDLE;
               busy_n       = 1'b0;
               frame_done_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   // state, payload and registered outputs; reset abandons any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         shift          <= 24'h0;
         cnt            <= 3'd0;
         last_tel       <= 1'b1;
         bus.trmt       <= 1'b0;
         bus.tx_data    <= 8'h00;
         bus.ack_gnt    <= 1'b0;
         bus.tel_gnt    <= 1'b0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.frame_src  <= 1'b0;
      end else begin
         state          <= state_n;
         shift          <= shift_n;
         cnt            <= cnt_n;
         last_tel       <= last_tel_n;
         bus.trmt       <= trmt_n;
         bus.tx_data    <= tx_data_n;
         bus.ack_gnt    <= ack_gnt_n;
         bus.tel_gnt    <= tel_gnt_n;
         bus.busy       <= busy_n;
         bus.frame_done <= frame_done_n;
         bus.frame_src  <= frame_src_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench for uart_tx_sched with a frame-level reference model
module tb_uart_tx_sched;
   parameter bit ACK_PRI = 1'b0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   uart_tx_sched_if bus();
   uart_tx_sched #(.ACK_PRIORITY(ACK_PRI)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int ack_mode = 0, tel_mode = 0, ack_shots = 0, tel_shots = 0, ack_fired = 0, tel_fired = 0;
   int hold_low = 0, rand_pay = 0;
   logic [7:0]  ack_val = 8'hA5;
   logic [23:0] tel_val = 24'h123456;
   logic [7:0]  tx_log[$];
   int          gnt_log[$];
   int          trmt_cnt = 0, fd_cnt = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // reference model: frame queue plus the timing rules (grant one cycle after sampled req, tx_done honoured from the third edge after trmt)
   logic       m_busy = 1'b0, m_last_tel = 1'b1, pa;
   int         m_age = 0;
   logic [7:0] mq[$];
   logic [7:0] cs;
   logic       e_trmt = 0, e_ag = 0, e_tg = 0, e_busy = 0, e_fd = 0, e_src = 0;
   logic [7:0] e_data = 8'h00;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_last_tel = 1; m_age = 0; mq.delete();
         e_trmt = 0; e_ag = 0; e_tg = 0; e_busy = 0; e_fd = 0; e_src = 0; e_data = 8'h00;
      end else begin
         e_trmt = 0; e_ag = 0; e_tg = 0; e_fd = 0;
         if (!m_busy) begin
            if (bus.ack_req || bus.tel_req) begin
               pa = bus.ack_req && (!bus.tel_req || ACK_PRI || m_last_tel);
               mq.delete();
               if (pa) mq.push_back(bus.ack_byte);
               else begin
                  mq.push_back(bus.tel_data[23:16]);
                  mq.push_back(bus.tel_data[15:8]);
                  mq.push_back(bus.tel_data[7:0]);
`ifdef TEL_CHKSUM_EN
                  cs = bus.tel_data[23:16] + bus.tel_data[15:8] + bus.tel_data[7:0];
                  mq.push_back(cs);
`endif
               end
               e_data = mq.pop_front();
               e_trmt = 1; e_ag = pa; e_tg = !pa; e_src = !pa; m_last_tel = !pa;
               e_busy = 1; m_busy = 1; m_age = 0;
            end
         end else if (m_age >= 2 && bus.tx_done) begin
            if (mq.size() > 0) begin
               e_data = mq.pop_front(); e_trmt = 1; m_age = 0;
            end else begin
               e_fd = 1; e_busy = 0; m_busy = 0;
            end
         end else m_age++;
      end
   end

   // per-cycle compare against the model, plus logs for the directed checks
   always @(negedge clk) begin
      if (rst_n) begin
         chk("trmt", bus.trmt, e_trmt);
         chk("tx_data", bus.tx_data, e_data);
         chk("ack_gnt", bus.ack_gnt, e_ag);
         chk("tel_gnt", bus.tel_gnt, e_tg);
         chk("busy", bus.busy, e_busy);
         chk("frame_done", bus.frame_done, e_fd);
         chk("frame_src", bus.frame_src, e_src);
         if (bus.trmt) begin tx_log.push_back(bus.tx_data); trmt_cnt++; end
         if (bus.ack_gnt) gnt_log.push_back(0);
         if (bus.tel_gnt) gnt_log.push_back(1);
         if (bus.frame_done) fd_cnt++;
      end
   end

   // requesters: hold req until grant (continuous mode keeps it high), payload refreshed every cycle
   initial begin
      bus.ack_req = 0; bus.tel_req = 0; bus.ack_byte = 8'h00; bus.tel_data = 24'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.ack_byte = rand_pay != 0 ? 8'($urandom) : ack_val;
         bus.tel_data = rand_pay != 0 ? 24'($urandom) : tel_val;
         if (!rst_n) bus.ack_req = 0;
         else if (bus.ack_req) begin if (bus.ack_gnt && ack_mode != 2) bus.ack_req = 0; end
         else if (ack_mode == 2 || (ack_mode == 1 && $urandom_range(0, 7) == 0)) bus.ack_req = 1;
         else if (ack_fired < ack_shots) begin bus.ack_req = 1; ack_fired++; end
         if (!rst_n) bus.tel_req = 0;
         else if (bus.tel_req) begin if (bus.tel_gnt && tel_mode != 2) bus.tel_req = 0; end
         else if (tel_mode == 2 || (tel_mode == 1 && $urandom_range(0, 7) == 0)) bus.tel_req = 1;
         else if (tel_fired < tel_shots) begin bus.tel_req = 1; tel_fired++; end
      end
   end

   // transmitter: drops tx_done on trmt, raises it again after a random delay unless held
   initial begin
      int d;
      bus.tx_done = 1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.trmt) begin
            bus.tx_done = 0;
            d = $urandom_range(0, 4);
            repeat (d) begin @(posedge clk); #1; end
            while (hold_low != 0) begin @(posedge clk); #1; end
            bus.tx_done = 1;
         end
      end
   end

   task automatic wait_frames(int n);
      int t = fd_cnt + n;
      int k = 0;
      while (fd_cnt < t && k < 3000) begin tick(); k++; end
      if (fd_cnt < t) begin checks++; errors++; $display("FAIL wait_frames: got %0d frames expected %0d", fd_cnt, t); end
   endtask

   task automatic wait_trmt(int n);
      int t = trmt_cnt + n;
      int k = 0;
      while (trmt_cnt < t && k < 3000) begin tick(); k++; end
      if (trmt_cnt < t) begin checks++; errors++; $display("FAIL wait_trmt: got %0d strobes expected %0d", trmt_cnt, t); end
   endtask

   task automatic drain();
      int q = 0;
      int k = 0;
      while (q < 6 && k < 3000) begin
         tick();
         k++;
         q = (!bus.busy && !bus.ack_req && !bus.tel_req) ? q + 1 : 0;
      end
      if (q < 6) begin checks++; errors++; $display("FAIL drain: got busy=%0b expected idle", bus.busy); end
   endtask

   task automatic chk_bytes(string name, int m, logic [7:0] exp[$]);
      chk({name, "_len"}, tx_log.size() - m, exp.size());
      foreach (exp[i]) chk(name, (m + i < tx_log.size()) ? tx_log[m + i] : 8'hxx, exp[i]);
   endtask

   initial begin
      int m, g, f;
      logic [7:0] tel_exp[$];
      logic [7:0] e[$];
      tel_exp = '{8'h12, 8'h34, 8'h56};
`ifdef TEL_CHKSUM_EN
      tel_exp.push_back(8'h9C);
`endif
      repeat (3) tick();
      chk("rst_trmt", bus.trmt, 0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_gnts", {bus.ack_gnt, bus.tel_gnt}, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_frame_src", bus.frame_src, 0);
      rst_n = 1;
      repeat (2) tick();

      m = tx_log.size(); g = gnt_log.size();
      ack_shots++;
      wait_frames(1);
      e = '{8'hA5};
      chk_bytes("ack_only", m, e);
      chk("ack_only_src", gnt_log[g], 0);
      chk("ack_only_frame_src", bus.frame_src, 0);

      m = tx_log.size(); g = gnt_log.size();
      tel_shots++;
      wait_frames(1);
      chk_bytes("tel_only", m, tel_exp);
      chk("tel_only_gnts", gnt_log.size() - g, 1);
      chk("tel_only_frame_src", bus.frame_src, 1);

      m = tx_log.size(); g = gnt_log.size();
      ack_shots++; tel_shots++;
      wait_frames(2);
      chk("tie_first", gnt_log[g], 0);
      chk("tie_second", gnt_log[g + 1], 1);

      m = tx_log.size();
      tel_shots++;
      wait_trmt(2);
      ack_shots++;
      wait_frames(2);
      e = tel_exp;
      e.push_back(8'hA5);
      chk_bytes("no_interleave", m, e);

      g = gnt_log.size();
      ack_mode = 2; tel_mode = 2;
      for (int k = 0; k < 3000 && gnt_log.size() < g + 4; k++) tick();
      ack_mode = 0; tel_mode = 0;
      for (int i = 0; i < 4; i++) chk("continuous_src", gnt_log[g + i], ACK_PRI ? 0 : ((i % 2) == 0));
      drain();

      m = tx_log.size(); f = trmt_cnt;
      hold_low = 1;
      tel_shots++;
      repeat (500) tick();
      chk("hold_trmts", trmt_cnt - f, 1);
      chk("hold_busy", bus.busy, 1);
      hold_low = 0;
      wait_frames(1);
      chk_bytes("hold_resume", m, tel_exp);

      tel_shots++;
      wait_trmt(2);
      f = fd_cnt;
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_trmt", bus.trmt, 0);
      chk("arst_tx_data", bus.tx_data, 8'h00);
      chk("arst_gnts", {bus.ack_gnt, bus.tel_gnt}, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_frame_done", bus.frame_done, 0);
      chk("arst_frame_src", bus.frame_src, 0);
      repeat (3) tick();
      rst_n = 1;
      chk("arst_no_frame_done", fd_cnt, f);
      ack_val = 8'h3C;
      m = tx_log.size();
      ack_shots++;
      wait_frames(1);
      e = '{8'h3C};
      chk_bytes("post_reset_ack", m, e);
      chk("post_reset_frames", fd_cnt - f, 1);

      rand_pay = 1; ack_mode = 1; tel_mode = 1;
      repeat (5000) tick();
      ack_mode = 0; tel_mode = 0;
      drain();
      chk("random_frames_seen", fd_cnt > f + 50, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
